// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//
// Bit-serial magnitude comparator. Captures two WIDTH-bit operands on an
// accepted start and resolves A vs B MSB-first, one bit per clock.
//
// Parameters:
//   WIDTH      operand width in bits (2..64)
//   SIGNED     1 = two's-complement compare, 0 = unsigned
//   EARLY_EXIT 1 = finish at the first differing bit, 0 = always WIDTH cycles
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted only while busy=0
//   a, b   in   operands, captured on the accepting edge
//   busy   out  compare in progress
//   done   out  one-cycle pulse, g/e/l valid from this cycle
//   g/e/l  out  A > B / A == B / A < B, one-hot after done, 000 while busy

module serial_magnitude_comparator #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          SIGNED     = 1'b0,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);

    localparam int unsigned    IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IdxW-1:0]  idx_q;
    // First difference seen and its direction (used only in constant-time mode)
    logic             seen_q;
    logic             seen_gt_q;

    logic bit_a, bit_b, bit_diff, a_wins, last_bit, final_seen, final_gt;

    always_comb begin
        bit_a    = a_q[idx_q];
        bit_b    = b_q[idx_q];
        bit_diff = bit_a ^ bit_b;
        // The sign bit has negative weight: holding a 1 there means smaller.
        a_wins   = (SIGNED && (idx_q == IdxMax)) ? bit_b : bit_a;
        last_bit = (idx_q == '0);
        // Resolution at the last bit folds in a difference found on this very bit.
        final_seen = seen_q | bit_diff;
        final_gt   = seen_q ? seen_gt_q : a_wins;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= IdxMax;
            seen_q    <= 1'b0;
            seen_gt_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            g         <= 1'b0;
            e         <= 1'b0;
            l         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        idx_q     <= IdxMax;
                        seen_q    <= 1'b0;
                        seen_gt_q <= 1'b0;
                        g         <= 1'b0;
                        e         <= 1'b0;
                        l         <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (EARLY_EXIT && bit_diff) begin
                        g       <= a_wins;
                        l       <= ~a_wins;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        idx_q   <= IdxMax;
                        state_q <= StIdle;
                    end else if (last_bit) begin
                        g       <= final_seen & final_gt;
                        e       <= ~final_seen;
                        l       <= final_seen & ~final_gt;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        idx_q   <= IdxMax;
                        state_q <= StIdle;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                        if (!seen_q && bit_diff) begin
                            seen_q    <= 1'b1;
                            seen_gt_q <= a_wins;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator. Three instances cover the
// parameter corners: unsigned early-exit, signed early-exit and unsigned
// constant-time. A reference model predicts result and latency from plain
// integer arithmetic; directed tasks additionally pin literal expectations.

module tb_serial_magnitude_comparator;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] st    = '0;
    logic [2:0] busy, done, g, e, l;
    logic [7:0] av [3] = '{default: 8'h00};
    logic [7:0] bv [3] = '{default: 8'h00};

    int vectors     = 0;
    int miscompares = 0;

    bit       m_busy [3] = '{default: 1'b0};
    bit       m_done [3] = '{default: 1'b0};
    bit [2:0] m_gel  [3] = '{default: 3'b000};
    bit [2:0] m_res  [3] = '{default: 3'b000};
    int       m_cnt  [3] = '{default: 0};

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u_uns_early (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]),
        .busy(busy[0]), .done(done[0]), .g(g[0]), .e(e[0]), .l(l[0])
    );

    serial_magnitude_comparator #(.WIDTH(8), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) u_sgn_early (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]),
        .busy(busy[1]), .done(done[1]), .g(g[1]), .e(e[1]), .l(l[1])
    );

    serial_magnitude_comparator #(.WIDTH(8), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u_uns_const (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]),
        .busy(busy[2]), .done(done[2]), .g(g[2]), .e(e[2]), .l(l[2])
    );

    function automatic int calc_lat(input logic [7:0] x, input logic [7:0] y, input bit early);
        if (!early) return 8;
        for (int i = 7; i >= 0; i--) begin
            if (x[i] != y[i]) return 8 - i;
        end
        return 8;
    endfunction

    // {g,e,l} from integer compare
    function automatic bit [2:0] calc_gel(input logic [7:0] x, input logic [7:0] y, input bit sgn);
        int xi, yi;
        xi = sgn ? int'($signed(x)) : int'(x);
        yi = sgn ? int'($signed(y)) : int'(y);
        if (xi > yi) return 3'b100;
        if (xi == yi) return 3'b010;
        return 3'b001;
    endfunction

    // Reference model: instance 1 is signed, instance 2 is constant-time.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_gel[k]  = 3'b000;
                m_cnt[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_done[k] = 1'b0;
                if (!m_busy[k]) begin
                    if (st[k]) begin
                        m_busy[k] = 1'b1;
                        m_cnt[k]  = calc_lat(av[k], bv[k], k != 2);
                        m_res[k]  = calc_gel(av[k], bv[k], k == 1);
                        m_gel[k]  = 3'b000;
                    end
                end else begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_busy[k] = 1'b0;
                        m_done[k] = 1'b1;
                        m_gel[k]  = m_res[k];
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [4:0] act, req;
        for (int k = 0; k < 3; k++) begin
            act = {busy[k], done[k], g[k], e[k], l[k]};
            req = {m_busy[k], m_done[k], m_gel[k]};
            vectors++;
            if (act !== req) begin
                miscompares++;
                $display("FAIL cycle-check inst%0d t=%0t busy/done/g/e/l got %b required %b",
                         k, $time, act, req);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0h required %0h", name, $time, act, req);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic start_op(input int k, input logic [7:0] x, input logic [7:0] y);
        av[k]  = x;
        bv[k]  = y;
        st[k]  = 1'b1;
        @(posedge clk);
        #1;
        st[k]  = 1'b0;
    endtask

    // Counts edges after the accept edge until done; inj>0 pulses a start
    // sampled at edge N+inj with a=00, b=FF, which must be ignored.
    task automatic wait_done(input int k, input int lat, input bit [2:0] gel,
                             input string name, input int inj = 0);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (inj != 0 && n == inj) st[k] = 1'b0;
            if (inj != 0 && n == inj - 1) begin
                av[k] = 8'h00;
                bv[k] = 8'hFF;
                st[k] = 1'b1;
            end
            if (done[k] === 1'b1) seen = 1'b1;
        end
        check({name, " done-seen"}, int'(seen), 1);
        check({name, " latency"}, n, lat);
        check({name, " gel"}, int'({g[k], e[k], l[k]}), int'(gel));
        check({name, " busy"}, int'(busy[k]), 0);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            check("reset-state", int'({busy[k], done[k], g[k], e[k], l[k]}), 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-operation: abandoned before its done edge
        start_op(0, 8'h12, 8'h34);
        @(posedge clk);
        #1;
        #2 rst_n = 1'b0;
        #1 check("async-reset", int'({busy[0], done[0], g[0], e[0], l[0]}), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_op(0, 8'h34, 8'h12);
        wait_done(0, 3, 3'b100, "rst-recover 34>12");

        // Unsigned early-exit
        start_op(0, 8'h80, 8'h7F);
        wait_done(0, 1, 3'b100, "uns 80>7F");
        start_op(0, 8'h03, 8'h02);
        wait_done(0, 8, 3'b100, "uns 03>02");
        start_op(0, 8'h5A, 8'h5A);
        wait_done(0, 8, 3'b010, "uns 5A==5A");
        repeat (3) @(posedge clk);
        #1 check("eq-held", int'({done[0], g[0], e[0], l[0]}), 4'b0010);
        start_op(0, 8'h12, 8'h34);
        wait_done(0, 3, 3'b001, "uns 12<34");
        // Back-to-back from the done cycle
        start_op(0, 8'h01, 8'h02);
        check("b2b-uns clear", int'({busy[0], g[0], e[0], l[0]}), 4'b1000);
        wait_done(0, 7, 3'b001, "uns 01<02");

        // Signed early-exit
        start_op(1, 8'h80, 8'h01);
        wait_done(1, 1, 3'b001, "sgn 80<01");
        start_op(1, 8'hFF, 8'hFE);
        wait_done(1, 8, 3'b100, "sgn FF>FE");
        start_op(1, 8'h7F, 8'h80);
        wait_done(1, 1, 3'b100, "sgn 7F>80");
        start_op(1, 8'h00, 8'hFF);
        wait_done(1, 1, 3'b100, "sgn 00>FF");
        start_op(1, 8'hA5, 8'hA5);
        wait_done(1, 8, 3'b010, "sgn A5==A5");

        // Constant-time, with an ignored start during RUN
        start_op(2, 8'hF0, 8'h0F);
        wait_done(2, 8, 3'b100, "const F0>0F", 3);
        start_op(2, 8'h01, 8'h02);
        check("b2b-const clear", int'({busy[2], g[2], e[2], l[2]}), 4'b1000);
        wait_done(2, 8, 3'b001, "const 01<02");
        start_op(2, 8'h80, 8'h7F);
        wait_done(2, 8, 3'b100, "const 80>7F");
        start_op(2, 8'h33, 8'h33);
        wait_done(2, 8, 3'b010, "const 33==33");

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
